// File: rtl/hls_deadlock_param_monitor.sv
// Parametrised deadlock monitor: flags a stall that persists THRESHOLD cycles and latches its cause.
// Optional feature: define HLS_DEADLOCK_STICKY_EN to hold BLOCKED until clear or reset.
module hls_deadlock_param_monitor #(
   parameter int NUM_AXIS  = 2,
   parameter int NUM_INST  = 1,
   parameter int THRESHOLD = 1,
   parameter int CNT_W     = 16
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [NUM_AXIS-1:0]             axis_block_sigs,
   input  logic [NUM_INST-1:0]             inst_idle_sigs,
   input  logic [NUM_INST-1:0]             inst_block_sigs,
   input  logic                            clear,
   output logic                            block,
   output logic [$clog2(NUM_AXIS+1)-1:0]   block_chan,
   output logic [CNT_W-1:0]                block_events
);

   localparam int CHAN_W = $clog2(NUM_AXIS + 1);
   localparam int RUN_W  = $clog2(THRESHOLD + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_BLOCKED = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
   logic                block_q, block_d;
   logic [CHAN_W-1:0]   block_chan_q, block_chan_d;
   logic [CNT_W-1:0]    block_events_q, block_events_d;

   logic                cand;
   logic [CHAN_W-1:0]   first_chan;
   logic [RUN_W:0]      run_inc;
   logic                run_reached;
   logic [RUN_W-1:0]    run_sat;

   // Stall candidate, lowest blocked AXIS index, and saturated run increment.
   always_comb begin
      cand = (|axis_block_sigs)
           | ((&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs));
      first_chan = CHAN_W'(NUM_AXIS);
      for (int i = NUM_AXIS - 1; i >= 0; i--) begin
         if (axis_block_sigs[i]) begin
            first_chan = CHAN_W'(i);
         end else begin
            first_chan = first_chan;
         end
      end
      run_inc     = {1'b0, run_cnt_q} + (RUN_W + 1)'(1);
      run_reached = (run_inc >= (RUN_W + 1)'(THRESHOLD));
      if (run_reached) begin
         run_sat = RUN_W'(THRESHOLD);
      end else begin
         run_sat = run_inc[RUN_W-1:0];
      end
   end

   // Next-state and capture logic; clear outranks a concurrent stall.
   always_comb begin
      state_d        = state_q;
      run_cnt_d      = run_cnt_q;
      block_chan_d   = block_chan_q;
      block_events_d = block_events_q;
      if (clear) begin
         state_d   = ST_IDLE;
         run_cnt_d = {RUN_W{1'b0}};
      end else if (cand) begin
         run_cnt_d = run_sat;
         if (run_reached) begin
            state_d = ST_BLOCKED;
            if (state_q != ST_BLOCKED) begin
               block_chan_d = first_chan;
               if (block_events_q != {CNT_W{1'b1}}) begin
                  block_events_d = block_events_q + CNT_W'(1);
               end else begin
                  block_events_d = block_events_q;
               end
            end else begin
               block_chan_d = block_chan_q;
            end
         end else begin
            state_d = ST_SUSPECT;
         end
      end else begin
`ifdef HLS_DEADLOCK_STICKY_EN
         if (state_q == ST_BLOCKED) begin
            state_d = ST_BLOCKED;
         end else begin
            state_d   = ST_IDLE;
            run_cnt_d = {RUN_W{1'b0}};
         end
`else
         state_d   = ST_IDLE;
         run_cnt_d = {RUN_W{1'b0}};
`endif
      end
      block_d = (state_d == ST_BLOCKED);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         run_cnt_q      <= {RUN_W{1'b0}};
         block_q        <= 1'b0;
         block_chan_q   <= {CHAN_W{1'b0}};
         block_events_q <= {CNT_W{1'b0}};
      end else begin
         state_q        <= state_d;
         run_cnt_q      <= run_cnt_d;
         block_q        <= block_d;
         block_chan_q   <= block_chan_d;
         block_events_q <= block_events_d;
      end
   end

   assign block        = block_q;
   assign block_chan   = block_chan_q;
   assign block_events = block_events_q;

endmodule

// File: tb/tb_hls_deadlock_param_monitor.sv
// Bench for hls_deadlock_param_monitor: two instances (THRESHOLD=1 and THRESHOLD=4) against a run-length model.
module tb_hls_deadlock_param_monitor;

   logic        clock = 1'b0;
   logic        reset, clear;
   logic [1:0]  ax2;
   logic [3:0]  ax4;
   logic [1:0]  idle, iblk;
   logic        b1, b4;
   logic [1:0]  c1;
   logic [2:0]  c4;
   logic [15:0] e1;
   logic [2:0]  e4;
   int vectors = 0;
   int miscompares = 0;

`ifdef HLS_DEADLOCK_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   typedef struct {int run; bit blk; int chan; int ev;} mdl_t;
   mdl_t m1, m4;

   always #5 clock = ~clock;

   hls_deadlock_param_monitor #(.NUM_AXIS(2), .NUM_INST(2), .THRESHOLD(1), .CNT_W(16)) dut1 (
      .clock(clock), .reset(reset), .axis_block_sigs(ax2), .inst_idle_sigs(idle),
      .inst_block_sigs(iblk), .clear(clear), .block(b1), .block_chan(c1), .block_events(e1));

   hls_deadlock_param_monitor #(.NUM_AXIS(4), .NUM_INST(2), .THRESHOLD(4), .CNT_W(3)) dut4 (
      .clock(clock), .reset(reset), .axis_block_sigs(ax4), .inst_idle_sigs(idle),
      .inst_block_sigs(iblk), .clear(clear), .block(b4), .block_chan(c4), .block_events(e4));

   // Model: count consecutive stall cycles; blocked once the run reaches the threshold.
   function automatic mdl_t mstep(mdl_t m, int thr, int na, int evmax, logic [3:0] ax,
                                  logic [1:0] idl, logic [1:0] blk, bit rst, bit clr);
      mdl_t r = m;
      bit cand = (ax != 4'd0) || (((idl | blk) == 2'b11) && (blk != 2'b00));
      int low = na;
      for (int i = na - 1; i >= 0; i--) if (ax[i]) low = i;
      if (rst) begin
         r.run = 0; r.blk = 0; r.chan = 0; r.ev = 0;
      end else if (clr) begin
         r.run = 0; r.blk = 0;
      end else if (cand) begin
         r.run = m.run + 1;
         if (r.run >= thr) begin
            if (!m.blk) begin
               r.chan = low;
               if (m.ev < evmax) r.ev = m.ev + 1;
            end
            r.blk = 1;
         end else begin
            r.blk = 0;
         end
      end else if (!(STICKY && m.blk)) begin
         r.run = 0; r.blk = 0;
      end
      return r;
   endfunction

   task automatic cycle();
      @(posedge clock);
      m1 = mstep(m1, 1, 2, 65535, {2'b00, ax2}, idle, iblk, reset, clear);
      m4 = mstep(m4, 4, 4, 7, ax4, idle, iblk, reset, clear);
      #1;
   endtask

   task automatic do_clear();
      ax2 = 2'd0; ax4 = 4'd0; idle = 2'd0; iblk = 2'd0;
      clear = 1'b1; cycle(); clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; clear = 1'b0; ax2 = 2'd0; ax4 = 4'd0; idle = 2'd0; iblk = 2'd0;
      cycle(); cycle();
      vectors++;
      if ({b1, c1, e1, b4, c4, e4} !== 25'd0) begin
         miscompares++;
         $display("FAIL reset: got b1=%0b c1=%0d e1=%0d b4=%0b c4=%0d e4=%0d, want all 0", b1, c1, e1, b4, c4, e4);
      end
      reset = 1'b0;
   endtask

   task automatic test_thresh1();
      ax2 = 2'b01; cycle(); ax2 = 2'b00;
      vectors++;
      if ({b1, c1, e1} !== {1'b1, 2'd0, 16'd1}) begin
         miscompares++;
         $display("FAIL thresh1_entry: got b=%0b chan=%0d ev=%0d, want 1 0 1", b1, c1, e1);
      end
      cycle();
      vectors++;
      if (b1 !== STICKY) begin
         miscompares++;
         $display("FAIL thresh1_drop: got block=%0b, want %0b", b1, STICKY);
      end
      do_clear();
   endtask

   task automatic test_interrupted();
      bit pat [7] = '{1, 1, 1, 0, 1, 1, 1};
      for (int i = 0; i < 7; i++) begin
         ax4 = pat[i] ? 4'b1000 : 4'b0000;
         cycle();
         vectors++;
         if ({b4, e4} !== {1'b0, 3'd0} || m4.blk) begin
            miscompares++;
            $display("FAIL interrupted[%0d]: got b=%0b ev=%0d, want 0 0", i, b4, e4);
         end
      end
      do_clear();
   endtask

   task automatic test_axis_chan();
      ax4 = 4'b0110; ax2 = 2'b10;
      for (int i = 0; i < 4; i++) begin
         cycle();
         vectors++;
         if (b4 !== (i == 3)) begin
            miscompares++;
            $display("FAIL axis_run[%0d]: got block=%0b, want %0b", i, b4, (i == 3));
         end
      end
      vectors++;
      if ({c4, e4, c1} !== {3'd1, 3'd1, 2'd1}) begin
         miscompares++;
         $display("FAIL axis_chan: got c4=%0d e4=%0d c1=%0d, want 1 1 1", c4, e4, c1);
      end
      do_clear();
   endtask

   task automatic test_inst_level();
      idle = 2'b01; iblk = 2'b10;
      for (int i = 0; i < 4; i++) cycle();
      vectors++;
      if ({b4, c4, e4, b1, c1} !== {1'b1, 3'd4, 3'd2, 1'b1, 2'd2}) begin
         miscompares++;
         $display("FAIL inst_block: got b4=%0b c4=%0d e4=%0d b1=%0b c1=%0d, want 1 4 2 1 2", b4, c4, e4, b1, c1);
      end
      do_clear();
      idle = 2'b00; iblk = 2'b10;
      for (int i = 0; i < 4; i++) cycle();
      vectors++;
      if ({b4, b1} !== 2'b00) begin
         miscompares++;
         $display("FAIL inst_noblock: got b4=%0b b1=%0b, want 0 0", b4, b1);
      end
      do_clear();
   endtask

   task automatic test_drop();
      int ev0;
      ax4 = 4'b0001;
      for (int i = 0; i < 4; i++) cycle();
      ev0 = m4.ev;
      ax4 = 4'b0000;
      cycle();
      vectors++;
      if (b4 !== STICKY) begin
         miscompares++;
         $display("FAIL drop: got block=%0b, want %0b", b4, STICKY);
      end
      cycle();
      vectors++;
      if (b4 !== STICKY) begin
         miscompares++;
         $display("FAIL drop_hold: got block=%0b, want %0b", b4, STICKY);
      end
      if (STICKY) begin
         clear = 1'b1; cycle(); clear = 1'b0;
      end
      ax4 = 4'b0100;
      for (int i = 0; i < 4; i++) cycle();
      vectors++;
      if ({b4, c4, e4} !== {1'b1, 3'd2, 3'(ev0 + 1)}) begin
         miscompares++;
         $display("FAIL restall: got b=%0b chan=%0d ev=%0d, want 1 2 %0d", b4, c4, e4, ev0 + 1);
      end
      do_clear();
   endtask

   task automatic test_clear_reset();
      ax4 = 4'b1000;
      cycle(); cycle();
      clear = 1'b1; cycle(); clear = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         vectors++;
         if (b4 !== (i == 3)) begin
            miscompares++;
            $display("FAIL clear_restart[%0d]: got block=%0b, want %0b", i, b4, (i == 3));
         end
      end
      reset = 1'b1; cycle(); reset = 1'b0; ax4 = 4'b0000;
      vectors++;
      if ({b4, c4, e4, b1, c1, e1} !== 25'd0) begin
         miscompares++;
         $display("FAIL reset_mid: got b4=%0b c4=%0d e4=%0d b1=%0b, want all 0", b4, c4, e4, b1);
      end
   endtask

   task automatic test_random();
      int hold = 0;
      for (int n = 0; n < 600; n++) begin
         if (hold == 0) begin
            hold = $urandom_range(1, 8);
            ax2  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            ax4  = ($urandom_range(0, 4) < 3) ? 4'($urandom) : 4'b0000;
            idle = 2'($urandom);
            iblk = 2'($urandom);
         end
         hold--;
         clear = ($urandom_range(0, 19) == 0);
         reset = ($urandom_range(0, 99) == 0);
         cycle();
         vectors++;
         if ({b1, c1, e1} !== {m1.blk, 2'(m1.chan), 16'(m1.ev)}) begin
            miscompares++;
            $display("FAIL rand1[%0d]: got b=%0b c=%0d e=%0d, want %0b %0d %0d", n, b1, c1, e1, m1.blk, m1.chan, m1.ev);
         end
         vectors++;
         if ({b4, c4, e4} !== {m4.blk, 3'(m4.chan), 3'(m4.ev)}) begin
            miscompares++;
            $display("FAIL rand4[%0d]: got b=%0b c=%0d e=%0d, want %0b %0d %0d", n, b4, c4, e4, m4.blk, m4.chan, m4.ev);
         end
      end
      reset = 1'b0; clear = 1'b0;
   endtask

   initial begin
      m1 = '{0, 0, 0, 0};
      m4 = '{0, 0, 0, 0};
      test_reset();
      test_thresh1();
      test_interrupted();
      test_axis_chan();
      test_inst_level();
      test_drop();
      test_clear_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
